aes128_csr: RTL and testbench
=============================

AES128_CSR -- requirements
Module: aes128_csr

Interface
REQ-001 SHALL have parameter AFU_ID_L, default 64'h0, meaning lower 64 bits of the AFU UUID returned at byte offset 0x008.
REQ-002 SHALL have parameter AFU_ID_H, default 64'h0, meaning upper 64 bits of the AFU UUID returned at byte offset 0x010.
REQ-003 SHALL have parameter N_BUF, default 3, meaning number of buffer descriptors (address + size).
REQ-004 clk  in  1  the single clock; all logic on its rising edge.
REQ-005 SoftReset  in  1  reset, asynchronous, active-high.
REQ-006 mmio_wr_valid  in  1  MMIO write strobe, one cycle per request.
REQ-007 mmio_rd_valid  in  1  MMIO read strobe, one cycle per request.
REQ-008 mmio_addr  in  16  MMIO address in 32-bit word units (byte offset >> 2).
REQ-009 mmio_tid  in  9  read transaction ID.
REQ-010 mmio_wdata  in  64  write data.
REQ-011 rsp_valid / rsp_tid / rsp_data  out  1/9/64  MMIO read response.
REQ-012 dsm_base  out  64  DSM base address register.
REQ-013 buf_addr / buf_size  out  N_BUF*64 / N_BUF*32  packed descriptors, entry i at [i].
REQ-014 afu_rst  out  1  high while the control FSM is in RESET.
REQ-015 start_pulse / stop_pulse  out  1/1  single-cycle commands to the read/write engines.
REQ-016 running  out  1  high while the control FSM is in RUNNING.
REQ-017 done  in  1  level from the write engine, marks job complete.

Function
REQ-018 Decode SHALL apply only when mmio_addr < 16'h100; other addresses are ignored for writes and return 0 on reads.
REQ-019 Write decode: 0x110 -> dsm_base; 0x118 -> control; 0x120+0x10*i -> buf_addr[i]; 0x128+0x10*i -> buf_size[i] (wdata[31:0]), for i < N_BUF (byte offsets, divide by 4 to compare with mmio_addr).
REQ-020 Register writes SHALL take effect the cycle after mmio_wr_valid.
REQ-021 buf_addr/buf_size writes SHALL be ignored while running=1; dsm_base writes likewise.
REQ-022 Control FSM states: RESET, IDLE, RUNNING, DONE; reset state RESET.
REQ-023 Control write with wdata[31:0]=0x0 SHALL move any state to RESET.
REQ-024 Value 0x1: RESET->IDLE; ignored elsewhere.
REQ-025 Value 0x3: IDLE or DONE -> RUNNING with start_pulse high exactly one cycle; ignored in RESET/RUNNING.
REQ-026 Value 0x7: RUNNING->IDLE with stop_pulse high exactly one cycle; ignored elsewhere.
REQ-027 done=1 while RUNNING SHALL move to DONE; a same-cycle control write takes priority over done.
REQ-028 Any other control value SHALL be ignored.
REQ-029 Reads: response exactly 1 cycle after mmio_rd_valid, rsp_tid = captured mmio_tid, rsp_valid high one cycle.
REQ-030 Read map: 0x000 DFH {4'b0001 type AFU, 19'b0, 1 EOL, 40'b0}; 0x008 AFU_ID_L; 0x010 AFU_ID_H; 0x018/0x020 zero; 0x108 status {60'b0, state one-hot DONE,RUNNING,IDLE,RESET}; all writable registers read back their value (size zero-extended).
REQ-031 Simultaneous rd_valid and wr_valid to the same register SHALL return the pre-write value.

Reset
REQ-032 On SoftReset assertion, immediately: all registers 0, FSM RESET, afu_rst=1, running/start_pulse/stop_pulse/rsp_valid=0.
REQ-033 SoftReset mid-RUNNING SHALL abort with no stop_pulse; a pending read response is dropped.

Verification
REQ-034 Reset, write 0x1 then 0x3 to 0x118 -> afu_rst falls, start_pulse one cycle, running=1, status read = 0x4.
REQ-035 Write 0x1000 to 0x120, 0x40 to 0x128, 0x2000 to 0x140 -> buf_addr[0]=0x1000, buf_size[0]=0x40, buf_addr[2]=0x2000; readback matches.
REQ-036 While running, write 0xDEAD to 0x130 -> buf_addr[1] unchanged.
REQ-037 Read 0x008 with tid 0x1A5 -> next cycle rsp_valid=1, rsp_tid=0x1A5, rsp_data=AFU_ID_L.
REQ-038 done=1 same cycle as write 0x7 -> IDLE, stop_pulse=1; later done=1 in RUNNING -> DONE, status 0x8; write 0x3 -> RUNNING.
REQ-039 SoftReset pulse mid-RUNNING -> all outputs zero, afu_rst=1, next write 0x3 ignored.

Source files
------------

// File: rtl/aes128_csr_if.sv
// rtl/aes128_csr_if.sv - MMIO request/response bundle for the AES-128 AFU CSR block
//
// Purpose: groups the host MMIO request strobes and the read-response path.
// Ports:
//   mmio_wr_valid / mmio_rd_valid  request strobes, one cycle per request
//   mmio_addr      address in 32-bit word units
//   mmio_tid       read transaction ID
//   mmio_wdata     write data
//   rsp_valid / rsp_tid / rsp_data  read response
// Modports: master drives requests, slave (the CSR block) answers them.

interface aes128_csr_if;
  logic        mmio_wr_valid;
  logic        mmio_rd_valid;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_wdata;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;

  modport master (
    output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata,
    input  rsp_valid, rsp_tid, rsp_data
  );

  modport slave (
    input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata,
    output rsp_valid, rsp_tid, rsp_data
  );
endinterface

// File: rtl/aes128_csr.sv
// rtl/aes128_csr.sv - AES-128 AFU control/status register block with job control FSM
//
// Purpose: MMIO-decoded DSM base, buffer descriptors and a RESET/IDLE/RUNNING/DONE
// control FSM that issues single-cycle start/stop commands to the engines.
// Ports:
//   clk, SoftReset (async, active-high)
//   mmio          aes128_csr_if.slave request/response bundle
//   dsm_base      DSM base address register
//   buf_addr/buf_size  packed descriptors, entry i at [i]
//   afu_rst, running   FSM state indications
//   start_pulse, stop_pulse  single-cycle engine commands
//   done          job-complete level from the write engine

module aes128_csr #(
  parameter logic [63:0] AFU_ID_L = 64'h0,
  parameter logic [63:0] AFU_ID_H = 64'h0,
  parameter int          N_BUF    = 3
) (
  input  logic                 clk,
  input  logic                 SoftReset,
  aes128_csr_if.slave          mmio,
  output logic [63:0]          dsm_base,
  output logic [N_BUF*64-1:0]  buf_addr,
  output logic [N_BUF*32-1:0]  buf_size,
  output logic                 afu_rst,
  output logic                 start_pulse,
  output logic                 stop_pulse,
  output logic                 running,
  input  logic                 done
);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RUNNING = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Word addresses (byte offset >> 2)
  localparam logic [15:0] A_DFH    = 16'h000;
  localparam logic [15:0] A_ID_L   = 16'h002;
  localparam logic [15:0] A_ID_H   = 16'h004;
  localparam logic [15:0] A_STATUS = 16'h042;
  localparam logic [15:0] A_DSM    = 16'h044;
  localparam logic [15:0] A_CTRL   = 16'h046;
  localparam logic [15:0] A_BUF    = 16'h048;

  localparam logic [63:0] DFH = {4'b0001, 19'b0, 1'b1, 40'b0};

  state_e      state_q, state_d;
  logic        start_pulse_q, stop_pulse_q;
  logic [63:0] dsm_base_q, dsm_base_d;
  logic [63:0] buf_addr_q [N_BUF];
  logic [63:0] buf_addr_d [N_BUF];
  logic [31:0] buf_size_q [N_BUF];
  logic [31:0] buf_size_d [N_BUF];
  logic        rsp_valid_q;
  logic [8:0]  rsp_tid_q;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic        addr_ok, ctrl_wr, reg_wr;
  logic [3:0]  status;

  assign addr_ok = mmio.mmio_addr < 16'h100;
  assign ctrl_wr = mmio.mmio_wr_valid && addr_ok && (mmio.mmio_addr == A_CTRL);
  // Descriptor and DSM registers are frozen while a job is running.
  assign reg_wr  = mmio.mmio_wr_valid && addr_ok && (state_q != ST_RUNNING);
  // One-hot {DONE, RUNNING, IDLE, RESET}
  assign status  = 4'b0001 << state_q;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge SoftReset) begin
    if (SoftReset) begin
      state_q       <= ST_RESET;
      start_pulse_q <= 1'b0;
      stop_pulse_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_pulse_q <= (state_q != ST_RUNNING) && (state_d == ST_RUNNING);
      stop_pulse_q  <= (state_q == ST_RUNNING) && (state_d == ST_IDLE);
    end
  end

  // Any control write in a cycle masks done for that cycle; done is a level,
  // so it is seen again on the next cycle if the write left the FSM RUNNING.
  always_comb begin
    state_d = state_q;
    if (ctrl_wr) begin
      case (mmio.mmio_wdata[31:0])
        32'h0: state_d = ST_RESET;
        32'h1: if (state_q == ST_RESET) state_d = ST_IDLE;
        32'h3: if (state_q == ST_IDLE || state_q == ST_DONE) state_d = ST_RUNNING;
        32'h7: if (state_q == ST_RUNNING) state_d = ST_IDLE;
        default: ;
      endcase
    end else if (done && state_q == ST_RUNNING) begin
      state_d = ST_DONE;
    end
  end

  always_comb begin
    afu_rst     = (state_q == ST_RESET);
    running     = (state_q == ST_RUNNING);
    start_pulse = start_pulse_q;
    stop_pulse  = stop_pulse_q;
  end

  // ---------------- register file ----------------
  always_comb begin
    dsm_base_d = dsm_base_q;
    buf_addr_d = buf_addr_q;
    buf_size_d = buf_size_q;
    if (reg_wr) begin
      if (mmio.mmio_addr == A_DSM) dsm_base_d = mmio.mmio_wdata;
      for (int i = 0; i < N_BUF; i++) begin
        if (mmio.mmio_addr == A_BUF + 16'(4 * i))     buf_addr_d[i] = mmio.mmio_wdata;
        if (mmio.mmio_addr == A_BUF + 16'(4 * i + 2)) buf_size_d[i] = mmio.mmio_wdata[31:0];
      end
    end
  end

  // Read data comes from the current (pre-write) register values.
  always_comb begin
    rsp_data_d = '0;
    if (addr_ok) begin
      case (mmio.mmio_addr)
        A_DFH:            rsp_data_d = DFH;
        A_ID_L:           rsp_data_d = AFU_ID_L;
        A_ID_H:           rsp_data_d = AFU_ID_H;
        A_STATUS, A_CTRL: rsp_data_d = {60'b0, status};
        A_DSM:            rsp_data_d = dsm_base_q;
        default:          ;
      endcase
      for (int i = 0; i < N_BUF; i++) begin
        if (mmio.mmio_addr == A_BUF + 16'(4 * i))     rsp_data_d = buf_addr_q[i];
        if (mmio.mmio_addr == A_BUF + 16'(4 * i + 2)) rsp_data_d = {32'b0, buf_size_q[i]};
      end
    end
  end

  always_ff @(posedge clk or posedge SoftReset) begin
    if (SoftReset) begin
      dsm_base_q  <= '0;
      for (int i = 0; i < N_BUF; i++) begin
        buf_addr_q[i] <= '0;
        buf_size_q[i] <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      dsm_base_q  <= dsm_base_d;
      buf_addr_q  <= buf_addr_d;
      buf_size_q  <= buf_size_d;
      rsp_valid_q <= mmio.mmio_rd_valid;
      if (mmio.mmio_rd_valid) begin
        rsp_tid_q  <= mmio.mmio_tid;
        rsp_data_q <= rsp_data_d;
      end
    end
  end

  assign dsm_base = dsm_base_q;
  for (genvar g = 0; g < N_BUF; g++) begin : g_pack
    assign buf_addr[g*64 +: 64] = buf_addr_q[g];
    assign buf_size[g*32 +: 32] = buf_size_q[g];
  end

  assign mmio.rsp_valid = rsp_valid_q;
  assign mmio.rsp_tid   = rsp_tid_q;
  assign mmio.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_aes128_csr.sv
// tb/tb_aes128_csr.sv - self-checking bench for aes128_csr

module tb_aes128_csr;
  localparam logic [63:0] ID_L = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ID_H = 64'hFEDC_BA98_7654_3210;
  localparam int          NB   = 3;
  localparam logic [63:0] DFH_EXP = 64'h1000_0100_0000_0000;
  localparam logic [3:0]  S_RESET = 4'h1, S_IDLE = 4'h2, S_RUN = 4'h4, S_DONE = 4'h8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done = 1'b0;
  logic [63:0]      dsm_base;
  logic [NB*64-1:0] buf_addr;
  logic [NB*32-1:0] buf_size;
  logic afu_rst, start_pulse, stop_pulse, running;

  aes128_csr_if bus ();

  aes128_csr #(.AFU_ID_L(ID_L), .AFU_ID_H(ID_H), .N_BUF(NB)) dut (
    .clk(clk), .SoftReset(rst), .mmio(bus),
    .dsm_base(dsm_base), .buf_addr(buf_addr), .buf_size(buf_size),
    .afu_rst(afu_rst), .start_pulse(start_pulse), .stop_pulse(stop_pulse),
    .running(running), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]  m_status;
  logic [63:0] m_dsm;
  logic [63:0] m_baddr [NB];
  logic [31:0] m_bsize [NB];
  logic        m_start, m_stop, m_rv, m_ctrl;
  logic [8:0]  m_tid;
  logic [63:0] m_rdata;
  int          m_off;

  function automatic logic [63:0] m_read(input logic [15:0] word);
    int off;
    logic [63:0] v;
    v = '0;
    if (word >= 16'h100) return v;
    off = int'(word) * 4;
    if (off == 'h000) v = DFH_EXP;
    if (off == 'h008) v = ID_L;
    if (off == 'h010) v = ID_H;
    if (off == 'h108 || off == 'h118) v = {60'b0, m_status};
    if (off == 'h110) v = m_dsm;
    for (int i = 0; i < NB; i++) begin
      if (off == 'h120 + 16 * i) v = m_baddr[i];
      if (off == 'h128 + 16 * i) v = {32'b0, m_bsize[i]};
    end
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_status = S_RESET;
      m_dsm    = '0;
      for (int i = 0; i < NB; i++) begin
        m_baddr[i] = '0;
        m_bsize[i] = '0;
      end
      m_start = 1'b0; m_stop = 1'b0; m_rv = 1'b0;
      m_tid = '0; m_rdata = '0;
    end else begin
      m_start = 1'b0;
      m_stop  = 1'b0;
      m_ctrl  = 1'b0;
      m_rv    = bus.mmio_rd_valid;
      if (bus.mmio_rd_valid) begin
        m_tid   = bus.mmio_tid;
        m_rdata = m_read(bus.mmio_addr);
      end
      if (bus.mmio_wr_valid && bus.mmio_addr < 16'h100) begin
        m_off = int'(bus.mmio_addr) * 4;
        if (m_off == 'h118) begin
          m_ctrl = 1'b1;
          case (bus.mmio_wdata[31:0])
            32'h0: m_status = S_RESET;
            32'h1: if (m_status == S_RESET) m_status = S_IDLE;
            32'h3: if (m_status == S_IDLE || m_status == S_DONE) begin
              m_status = S_RUN; m_start = 1'b1;
            end
            32'h7: if (m_status == S_RUN) begin
              m_status = S_IDLE; m_stop = 1'b1;
            end
            default: ;
          endcase
        end else if (m_status != S_RUN) begin
          if (m_off == 'h110) m_dsm = bus.mmio_wdata;
          for (int i = 0; i < NB; i++) begin
            if (m_off == 'h120 + 16 * i) m_baddr[i] = bus.mmio_wdata;
            if (m_off == 'h128 + 16 * i) m_bsize[i] = bus.mmio_wdata[31:0];
          end
        end
      end
      if (!m_ctrl && done && m_status == S_RUN) m_status = S_DONE;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("afu_rst", afu_rst, m_status == S_RESET);
    chk("running", running, m_status == S_RUN);
    chk("start_pulse", start_pulse, m_start);
    chk("stop_pulse", stop_pulse, m_stop);
    chk("dsm_base", dsm_base, m_dsm);
    for (int i = 0; i < NB; i++) begin
      chk("buf_addr", buf_addr[i*64 +: 64], m_baddr[i]);
      chk("buf_size", buf_size[i*32 +: 32], m_bsize[i]);
    end
    chk("rsp_valid", bus.rsp_valid, m_rv);
    if (m_rv) begin
      chk("rsp_tid", bus.rsp_tid, m_tid);
      chk("rsp_data", bus.rsp_data, m_rdata);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    bus.mmio_wr_valid = 1'b1;
    bus.mmio_addr     = a;
    bus.mmio_wdata    = d;
    tick();
    bus.mmio_wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [8:0] t, output logic [63:0] d);
    bus.mmio_rd_valid = 1'b1;
    bus.mmio_addr     = a;
    bus.mmio_tid      = t;
    tick();
    bus.mmio_rd_valid = 1'b0;
    @(negedge clk);
    chk("rd_rsp_valid", bus.rsp_valid, 1'b1);
    chk("rd_rsp_tid", bus.rsp_tid, t);
    d = bus.rsp_data;
  endtask

  initial begin
    logic [63:0] d;
    bus.mmio_wr_valid = 1'b0;
    bus.mmio_rd_valid = 1'b0;
    bus.mmio_addr     = '0;
    bus.mmio_tid      = '0;
    bus.mmio_wdata    = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_afu_rst", afu_rst, 1'b1);
    chk("reset_running", running, 1'b0);
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    rst = 1'b0;
    tick();

    rd(16'h000, 9'h001, d); chk("dfh", d, 64'h1000_0100_0000_0000);
    rd(16'h002, 9'h1A5, d); chk("afu_id_l", d, 64'h0123_4567_89AB_CDEF);
    rd(16'h004, 9'h002, d); chk("afu_id_h", d, 64'hFEDC_BA98_7654_3210);
    rd(16'h006, 9'h003, d); chk("rsvd_018", d, 64'h0);
    rd(16'h008, 9'h004, d); chk("rsvd_020", d, 64'h0);
    rd(16'h042, 9'h005, d); chk("status_reset", d, 64'h1);

    wr(16'h044, 64'h0000_0001_2345_6780);
    rd(16'h044, 9'h006, d); chk("dsm_readback", d, 64'h0000_0001_2345_6780);

    wr(16'h048, 64'h1000);
    wr(16'h04A, 64'hFFFF_FFFF_0000_0040);
    wr(16'h050, 64'h2000);
    chk("buf_addr0", buf_addr[63:0], 64'h1000);
    chk("buf_size0", buf_size[31:0], 64'h40);
    chk("buf_addr2", buf_addr[191:128], 64'h2000);
    rd(16'h048, 9'h007, d); chk("buf_addr0_rd", d, 64'h1000);
    rd(16'h04A, 9'h008, d); chk("buf_size0_rd", d, 64'h40);
    rd(16'h052, 9'h009, d); chk("buf_size2_rd", d, 64'h0);

    wr(16'h046, 64'h3);
    rd(16'h042, 9'h00A, d); chk("start_in_reset_ignored", d, 64'h1);
    wr(16'h046, 64'h1);
    chk("afu_rst_low", afu_rst, 1'b0);
    rd(16'h042, 9'h00B, d); chk("status_idle", d, 64'h2);
    wr(16'h046, 64'h5);
    rd(16'h042, 9'h00C, d); chk("bad_ctrl_ignored", d, 64'h2);

    wr(16'h046, 64'h3);
    chk("start_pulse_hi", start_pulse, 1'b1);
    chk("running_hi", running, 1'b1);
    tick();
    chk("start_pulse_once", start_pulse, 1'b0);
    rd(16'h042, 9'h00D, d); chk("status_running", d, 64'h4);

    wr(16'h04C, 64'hDEAD);
    chk("buf_addr1_locked", buf_addr[127:64], 64'h0);
    wr(16'h044, 64'hBAD);
    chk("dsm_locked", dsm_base, 64'h0000_0001_2345_6780);

    done = 1'b1;
    wr(16'h046, 64'h7);
    done = 1'b0;
    chk("stop_pulse_hi", stop_pulse, 1'b1);
    chk("stop_to_idle", running, 1'b0);
    tick();
    chk("stop_pulse_once", stop_pulse, 1'b0);
    rd(16'h042, 9'h00E, d); chk("status_after_stop", d, 64'h2);

    wr(16'h046, 64'h3);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("done_leaves_running", running, 1'b0);
    rd(16'h042, 9'h00F, d); chk("status_done", d, 64'h8);
    wr(16'h046, 64'h3);
    chk("restart_pulse", start_pulse, 1'b1);
    rd(16'h042, 9'h010, d); chk("status_rerun", d, 64'h4);
    wr(16'h046, 64'h7);

    // read and write of the same register in one cycle
    bus.mmio_rd_valid = 1'b1;
    bus.mmio_wr_valid = 1'b1;
    bus.mmio_addr     = 16'h048;
    bus.mmio_tid      = 9'h077;
    bus.mmio_wdata    = 64'h5555;
    tick();
    bus.mmio_rd_valid = 1'b0;
    bus.mmio_wr_valid = 1'b0;
    @(negedge clk);
    chk("rw_same_valid", bus.rsp_valid, 1'b1);
    chk("rw_same_old", bus.rsp_data, 64'h1000);
    chk("rw_same_new", buf_addr[63:0], 64'h5555);

    // addresses at or above 0x100 are not decoded
    wr(16'h0148, 64'h9999);
    chk("oor_wr_ignored", buf_addr[63:0], 64'h5555);
    rd(16'h0142, 9'h011, d); chk("oor_rd_zero", d, 64'h0);

    // soft reset while running with a read response in flight
    wr(16'h046, 64'h3);
    bus.mmio_rd_valid = 1'b1;
    bus.mmio_addr     = 16'h042;
    bus.mmio_tid      = 9'h003;
    @(posedge clk);
    #1;
    bus.mmio_rd_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("srst_afu_rst", afu_rst, 1'b1);
    chk("srst_running", running, 1'b0);
    chk("srst_stop", stop_pulse, 1'b0);
    chk("srst_start", start_pulse, 1'b0);
    chk("srst_rsp_drop", bus.rsp_valid, 1'b0);
    chk("srst_dsm", dsm_base, 64'h0);
    chk("srst_buf_addr0", buf_addr[63:0], 64'h0);
    chk("srst_buf_size0", buf_size[31:0], 64'h0);
    tick();
    rst = 1'b0;
    wr(16'h046, 64'h3);
    chk("srst_start_ignored", running, 1'b0);
    rd(16'h042, 9'h012, d); chk("srst_status", d, 64'h1);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
